// File: rtl/piso_serializer.sv
// rtl/piso_serializer.sv - MSB-first parallel-in/serial-out transmitter with DIV-cycle bit periods and capture strobe
// Optional even-parity bit after the LSB when PISO_PARITY_EN is defined.
module piso_serializer #(
  parameter int WIDTH = 8,
  parameter int DIV   = 4
) (
  input  logic             Clk,
  input  logic             Rst,
  input  logic             Load,
  input  logic [WIDTH-1:0] Din,
  output logic             Ready,
  output logic             SerOut,
  output logic             SerEn,
  output logic             Done
);

`ifdef PISO_PARITY_EN
  localparam int NBITS = WIDTH + 1;
`else
  localparam int NBITS = WIDTH;
`endif
  localparam int DW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int BW = $clog2(NBITS + 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(DIV - 1);
  localparam logic [BW-1:0] BIT_LAST = BW'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
`ifdef PISO_PARITY_EN
    PARITY = 2'd2,
`endif
    SHIFT  = 2'd1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [BW-1:0]    bit_q, bit_d;
  logic [DW-1:0]    div_q, div_d;
  logic             ready_d, ser_d, sen_d, done_d;
`ifdef PISO_PARITY_EN
  logic             par_q, par_d;
`endif

  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    bit_d   = bit_q;
    div_d   = div_q;
    done_d  = 1'b0;
`ifdef PISO_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (Load) begin
          state_d = SHIFT;
          sh_d    = Din;
          bit_d   = '0;
          div_d   = '0;
`ifdef PISO_PARITY_EN
          par_d   = ^Din;
`endif
        end
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d = '0;
          sh_d  = {sh_q[WIDTH-2:0], 1'b0};
          bit_d = bit_q + 1'b1;
          if (bit_q == BIT_LAST) begin
`ifdef PISO_PARITY_EN
            state_d = PARITY;
`else
            state_d = IDLE;
            done_d  = 1'b1;
`endif
          end
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`ifdef PISO_PARITY_EN
      PARITY: begin
        if (div_q == DIV_LAST) begin
          div_d   = '0;
          state_d = IDLE;
          done_d  = 1'b1;
        end else begin
          div_d = div_q + 1'b1;
        end
      end
`endif
      default: state_d = IDLE;
    endcase

    // Outputs are computed from next-state values so they can be registered without adding latency.
    ready_d = (state_d == IDLE);
    sen_d   = (state_d != IDLE) && (div_d == DIV_LAST);
    ser_d   = 1'b0;
    if (state_d == SHIFT) begin
      ser_d = sh_d[WIDTH-1];
    end
`ifdef PISO_PARITY_EN
    else if (state_d == PARITY) begin
      ser_d = par_d;
    end
`endif
  end

  always_ff @(posedge Clk) begin
    if (Rst) begin
      state_q <= IDLE;
      sh_q    <= '0;
      bit_q   <= '0;
      div_q   <= '0;
      Ready   <= 1'b1;
      SerOut  <= 1'b0;
      SerEn   <= 1'b0;
      Done    <= 1'b0;
`ifdef PISO_PARITY_EN
      par_q   <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      Ready   <= ready_d;
      SerOut  <= ser_d;
      SerEn   <= sen_d;
      Done    <= done_d;
`ifdef PISO_PARITY_EN
      par_q   <= par_d;
`endif
    end
  end

endmodule

// File: tb/tb_piso_serializer.sv
// tb/tb_piso_serializer.sv - self-checking bench for piso_serializer (DIV=4 and DIV=1 instances)
module tb_piso_serializer;

  localparam int W = 8;
`ifdef PISO_PARITY_EN
  localparam int NB = W + 1;
`else
  localparam int NB = W;
`endif
  localparam int DONE4 = NB * 4 + 1;
  localparam int DONE1 = NB + 1;

  logic Clk = 1'b0;
  always #5 Clk = ~Clk;

  logic [1:0]   rst, load, ready, ser, sen, done;
  logic [W-1:0] din [2];

  piso_serializer #(.WIDTH(W), .DIV(4)) dut4 (
    .Clk(Clk), .Rst(rst[0]), .Load(load[0]), .Din(din[0]),
    .Ready(ready[0]), .SerOut(ser[0]), .SerEn(sen[0]), .Done(done[0])
  );
  piso_serializer #(.WIDTH(W), .DIV(1)) dut1 (
    .Clk(Clk), .Rst(rst[1]), .Load(load[1]), .Din(din[1]),
    .Ready(ready[1]), .SerOut(ser[1]), .SerEn(sen[1]), .Done(done[1])
  );

  int nchk = 0;
  int nerr = 0;
  int divs [2] = '{4, 1};

  // Reference model: position within the frame, counted in cycles since the accept edge.
  logic          m_busy  [2] = '{1'b0, 1'b0};
  int            m_t     [2];
  logic [NB-1:0] m_frame [2];
  logic          m_done  [2];

  logic [NB-1:0] cap [2];
  int since [2];
  int done_at [2];
  int ready_low [2];

  typedef struct {
    int           sel;
    logic [W-1:0] din;
    logic [W-1:0] bits;
    logic         par;
    int           done_cyc;
  } vec_t;
  vec_t vecs [5];

  function automatic logic [NB-1:0] frame_of(input logic [W-1:0] w);
`ifdef PISO_PARITY_EN
    return {w, ^w};
`else
    return w;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      if (nerr <= 40) $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic cycle();
    logic e_ser, e_sen;
    @(posedge Clk);
    for (int i = 0; i < 2; i++) begin
      m_done[i] = 1'b0;
      if (rst[i]) begin
        m_busy[i] = 1'b0;
      end else if (!m_busy[i] && load[i]) begin
        m_busy[i]  = 1'b1;
        m_t[i]     = 1;
        m_frame[i] = frame_of(din[i]);
      end else if (m_busy[i]) begin
        m_t[i]++;
        if (m_t[i] > NB * divs[i]) begin
          m_busy[i] = 1'b0;
          m_done[i] = 1'b1;
        end
      end
    end
    #1;
    for (int i = 0; i < 2; i++) begin
      e_ser = 1'b0;
      if (m_busy[i]) e_ser = m_frame[i][NB - 1 - (m_t[i] - 1) / divs[i]];
      e_sen = m_busy[i] && ((m_t[i] % divs[i]) == 0);
      chk($sformatf("ready_div%0d", divs[i]), 32'(ready[i]), 32'(!m_busy[i]));
      chk($sformatf("serout_div%0d", divs[i]), 32'(ser[i]), 32'(e_ser));
      chk($sformatf("seren_div%0d", divs[i]), 32'(sen[i]), 32'(e_sen));
      chk($sformatf("done_div%0d", divs[i]), 32'(done[i]), 32'(m_done[i]));
      since[i]++;
      if (sen[i] === 1'b1) cap[i] = {cap[i][NB-2:0], ser[i]};
      if (done[i] === 1'b1 && done_at[i] < 0) done_at[i] = since[i];
      if (ready[i] !== 1'b1) ready_low[i]++;
    end
  endtask

  task automatic launch(input int i, input logic [W-1:0] w);
    since[i]     = 0;
    cap[i]       = '0;
    done_at[i]   = -1;
    ready_low[i] = 0;
    load[i]      = 1'b1;
    din[i]       = w;
    cycle();
    load[i]      = 1'b0;
  endtask

  task automatic wait_done(input int i);
    int guard = 0;
    while (done_at[i] < 0 && guard < 200) begin
      cycle();
      guard++;
    end
    chk($sformatf("done_seen_div%0d", divs[i]), 32'(done_at[i] >= 0), 32'd1);
  endtask

  initial begin
    logic [NB-1:0] exp_frame;

    vecs[0] = '{0, 8'hA5, 8'b1010_0101, 1'b0, DONE4};
    vecs[1] = '{0, 8'h07, 8'b0000_0111, 1'b1, DONE4};
    vecs[2] = '{1, 8'h96, 8'b1001_0110, 1'b0, DONE1};
    vecs[3] = '{0, 8'hFF, 8'b1111_1111, 1'b0, DONE4};
    vecs[4] = '{1, 8'h81, 8'b1000_0001, 1'b0, DONE1};

    rst  = 2'b11;
    load = 2'b00;
    din[0] = '0;
    din[1] = '0;
    for (int c = 0; c < 3; c++) cycle();
    rst = 2'b00;
    cycle();

    for (int v = 0; v < 5; v++) begin
`ifdef PISO_PARITY_EN
      exp_frame = {vecs[v].bits, vecs[v].par};
`else
      exp_frame = vecs[v].bits;
`endif
      launch(vecs[v].sel, vecs[v].din);
      wait_done(vecs[v].sel);
      chk($sformatf("vec%0d_bits", v), 32'(cap[vecs[v].sel]), 32'(exp_frame));
      chk($sformatf("vec%0d_done_cycle", v), done_at[vecs[v].sel], vecs[v].done_cyc);
      chk($sformatf("vec%0d_ready_low", v), ready_low[vecs[v].sel], vecs[v].done_cyc - 1);
      cycle();
    end

    // Load while busy is ignored
    launch(0, 8'hA5);
    while (since[0] < 9) cycle();
    load[0] = 1'b1;
    din[0]  = 8'h3C;
    cycle();
    load[0] = 1'b0;
    wait_done(0);
    chk("busy_load_bits", 32'(cap[0]), 32'(frame_of(8'hA5)));
    chk("busy_load_done_cycle", done_at[0], DONE4);

    // Back-to-back load in the Done cycle
    launch(0, 8'hA5);
    wait_done(0);
    chk("b2b_first_done", done_at[0], DONE4);
    launch(0, 8'hFF);
    chk("b2b_accept_ser", 32'(ser[0]), 32'd1);
    chk("b2b_accept_ready", 32'(ready[0]), 32'd0);
    wait_done(0);
    chk("b2b_second_bits", 32'(cap[0]), 32'(frame_of(8'hFF)));
    chk("b2b_second_done", done_at[0], DONE4);

    // Reset mid-frame aborts without Done
    cycle();
    launch(0, 8'hA5);
    while (since[0] < 12) cycle();
    rst[0] = 1'b1;
    cycle();
    rst[0] = 1'b0;
    chk("abort_ready", 32'(ready[0]), 32'd1);
    chk("abort_ser", 32'(ser[0]), 32'd0);
    chk("abort_sen", 32'(sen[0]), 32'd0);
    for (int c = 0; c < 60; c++) cycle();
    chk("abort_no_done", done_at[0], -1);
    launch(0, 8'h81);
    wait_done(0);
    chk("after_abort_bits", 32'(cap[0]), 32'(frame_of(8'h81)));
    chk("after_abort_done", done_at[0], DONE4);

    // Reset wins over Load in the same cycle
    rst[1]  = 1'b1;
    load[1] = 1'b1;
    din[1]  = 8'hFF;
    cycle();
    rst[1]  = 1'b0;
    load[1] = 1'b0;
    cycle();
    chk("rst_prio_ready", 32'(ready[1]), 32'd1);
    chk("rst_prio_ser", 32'(ser[1]), 32'd0);

    // Randomized traffic against the model
    for (int c = 0; c < 600; c++) begin
      for (int i = 0; i < 2; i++) begin
        rst[i]  = ($urandom_range(0, 59) == 0);
        load[i] = ($urandom_range(0, 3) == 0);
        din[i]  = W'($urandom);
      end
      cycle();
    end
    rst  = 2'b00;
    load = 2'b00;
    for (int c = 0; c < 50; c++) cycle();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
